mem_port_arbiter: RTL and testbench

- Shares the single-ported unified memory between the fetch stage (IF) and the memory stage (MEM) of `pipeline_processor`.
- Runs a req/ack handshake toward memory with variable latency and a timeout.
- Drives per-requester stall signals so the pipeline freezes while its access is outstanding.
- Sits between the IF/MEM stage logic and the memory model, inside `pipeline_processor`.

---
 rtl/mem_port_arbiter.sv | 76 +++++++
 tb/tb_mem_port_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data with fixed data priority, wait timeout and stalls
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  output logic          if_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          d_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          timeout_err
);
  typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;
  localparam int CW = $clog2(MAX_WAIT + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic grant_d, grant_i, abort, fin;
  assign if_stall = if_req & ~if_valid;
  assign d_stall = d_req & ~d_valid;
  always_comb begin
    grant_d = state == IDLE && !if_valid && !d_valid && d_req;
    grant_i = state == IDLE && !if_valid && !d_valid && !d_req && if_req;
    abort = state != IDLE && !mem_ack && cnt == CW'(MAX_WAIT - 1);
    fin = state != IDLE && (mem_ack || abort);
    state_n = grant_d ? DATA : grant_i ? FETCH : fin ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_valid <= 1'b0;
      d_valid <= 1'b0;
      if_rdata <= '0;
      d_rdata <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= (state == IDLE) ? '0 : cnt + 1'b1;
      mem_req <= grant_d | grant_i | (mem_req & ~fin);
      if_valid <= fin && state == FETCH;
      d_valid <= fin && state == DATA;
      if (grant_d) begin
        mem_we <= d_we;
        mem_addr <= d_addr;
        mem_wdata <= d_wdata;
      end
      if (grant_i) begin
        mem_we <= 1'b0;
        mem_addr <= if_addr;
      end
      if (fin && state == FETCH) if_rdata <= mem_ack ? mem_rdata : '0;
      if (fin && state == DATA) d_rdata <= mem_ack ? mem_rdata : '0;
      if (abort) timeout_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed plan plus random traffic against a transaction-level memory and arbitration model
module tb_mem_port_arbiter;
  localparam int MW = 15;
  logic clk = 0, reset = 1;
  logic if_req = 0, d_req = 0, d_we = 0, mem_ack = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic if_valid, if_stall, d_valid, d_stall, mem_req, mem_we, timeout_err;
  int checks = 0, errors = 0;
  logic [31:0] mem [logic [31:0]];
  bit busy, own_d, ewe, pv, rnd, terr;
  int c, lat, next_lat;
  logic [31:0] ea, ewd, ack_data;
  always #5 clk = ~clk;
  mem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_valid(d_valid), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
  );
  function automatic logic [31:0] rd(logic [31:0] a);
    return mem.exists(a) ? mem[a] : ~a;
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    busy = 0; pv = 0; terr = 0; c = 0; mem_ack = 0;
  endtask
  task automatic do_reset();
    reset = 1;
    mem_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_timeout", timeout_err, 0);
    reset = 0;
    model_reset();
  endtask
  // one clock: retire/grant in the model, compare, then drive memory and requesters
  task automatic cyc();
    bit was_busy, evi, evd, g, acked;
    logic [31:0] er;
    was_busy = busy; evi = 0; evd = 0; acked = 0; er = 0;
    @(posedge clk);
    #1;
    if (busy) begin
      if (mem_ack || c == MW) begin
        evi = !own_d; evd = own_d; acked = mem_ack;
        er = mem_ack ? ack_data : 32'h0;
        if (!mem_ack) terr = 1;
        else if (own_d && ewe) mem[ea] = ewd;
        busy = 0;
      end else c++;
    end
    g = !was_busy && !pv && (d_req || if_req);
    chk("if_valid", if_valid, evi);
    chk("d_valid", d_valid, evd);
    if (evi) chk("if_rdata", if_rdata, er);
    if (evd && !(ewe && acked)) chk("d_rdata", d_rdata, er);
    chk("timeout_err", timeout_err, terr);
    chk("if_stall", if_stall, if_req & ~evi);
    chk("d_stall", d_stall, d_req & ~evd);
    chk("mem_req", mem_req, busy || g);
    if (g) begin
      busy = 1; c = 1; own_d = d_req;
      ewe = d_req & d_we;
      ea = d_req ? d_addr : if_addr;
      ewd = d_wdata;
      lat = rnd ? int'($urandom_range(1, MW + 2)) : next_lat;
    end
    if (busy) begin
      chk("mem_we", mem_we, ewe);
      chk("mem_addr", mem_addr, ea);
      if (ewe) chk("mem_wdata", mem_wdata, ewd);
    end
    pv = evi | evd;
    mem_ack = busy && c == lat;
    ack_data = rd(ea);
    mem_rdata = mem_ack ? ack_data : $urandom;
    if (evi) if_req = 0;
    if (evd) d_req = 0;
    if (rnd && !d_req && $urandom_range(0, 3) == 0) begin
      d_req = 1; d_we = 1'($urandom_range(0, 1));
      d_addr = 32'($urandom_range(0, 7) * 4); d_wdata = $urandom;
    end
    if (rnd && !if_req && $urandom_range(0, 2) == 0) begin
      if_req = 1; if_addr = 32'($urandom_range(0, 7) * 4);
    end
  endtask
  initial begin
    mem[32'h10] = 32'hDEADBEEF;
    rnd = 0;
    do_reset();
    if_req = 1; if_addr = 32'h10; next_lat = 1;
    #1 chk("t1_stall_c0", if_stall, 1);
    cyc();
    chk("t1_req_c1", mem_req, 1);
    chk("t1_stall_c1", if_stall, 1);
    cyc();
    chk("t1_valid_c2", if_valid, 1);
    chk("t1_rdata", if_rdata, 32'hDEADBEEF);
    chk("t1_stall_c2", if_stall, 0);
    cyc();
    d_req = 1; d_we = 0; d_addr = 32'h40; if_req = 1; if_addr = 32'h20; next_lat = 2;
    cyc();
    chk("t2_grant_d", mem_addr, 32'h40);
    chk("t2_stall", if_stall, 1);
    repeat (3) begin
      cyc();
      chk("t2_stall", if_stall, 1);
    end
    cyc();
    chk("t2_grant_if", mem_addr, 32'h20);
    chk("t2_stall", if_stall, 1);
    cyc();
    chk("t2_stall", if_stall, 1);
    cyc();
    chk("t2_if_done", if_valid, 1);
    cyc();
    d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'h12345678; next_lat = 4;
    repeat (4) begin
      cyc();
      chk("t3_req", mem_req, 1);
      chk("t3_we", mem_we, 1);
      chk("t3_wdata", mem_wdata, 32'h12345678);
    end
    cyc();
    chk("t3_valid", d_valid, 1);
    cyc();
    chk("t3_once", d_valid, 0);
    d_req = 1; d_we = 0; d_addr = 32'h44; next_lat = 100;
    repeat (MW) begin
      cyc();
      chk("t4_req", mem_req, 1);
    end
    cyc();
    chk("t4_valid", d_valid, 1);
    chk("t4_rdata", d_rdata, 0);
    chk("t4_err", timeout_err, 1);
    chk("t4_req_low", mem_req, 0);
    if_req = 1; if_addr = 32'h80; next_lat = 1;
    repeat (2) cyc();
    cyc();
    chk("t4_after", if_valid, 1);
    chk("t4_after_data", if_rdata, 32'h12345678);
    chk("t4_sticky", timeout_err, 1);
    do_reset();
    d_req = 1; d_we = 0; d_addr = 32'h80; next_lat = MW;
    repeat (MW) cyc();
    cyc();
    chk("t5_valid", d_valid, 1);
    chk("t5_rdata", d_rdata, 32'h12345678);
    chk("t5_no_err", timeout_err, 0);
    cyc();
    if_req = 1; if_addr = 32'h10; next_lat = 100;
    repeat (2) cyc();
    reset = 1;
    @(posedge clk);
    #1;
    chk("t6_req_off", mem_req, 0);
    chk("t6_no_valid", if_valid, 0);
    reset = 0;
    model_reset();
    next_lat = 1;
    cyc();
    chk("t6_regrant", mem_req, 1);
    cyc();
    chk("t6_done", if_valid, 1);
    chk("t6_rdata", if_rdata, 32'hDEADBEEF);
    cyc();
    rnd = 1;
    repeat (3000) cyc();
    rnd = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
